// File: rtl/multirate_v5_mac_pipe.sv
// Pipelined signed multiply-accumulate with frame-delimited accumulation,
// round-half-up scaling, output saturation and a global stall on backpressure.
module multirate_v5_mac_pipe #(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 13,
    parameter int ACC_WIDTH  = 40,
    parameter int DOUT_WIDTH = 16,
    parameter int SHIFT      = 12,
    parameter int NUM_STAGE  = 2
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_first,
    input  logic                         in_last,
    input  logic signed [DIN0_WIDTH-1:0] din0,
    input  logic signed [DIN1_WIDTH-1:0] din1,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         out_sat
);

    localparam int PW   = DIN0_WIDTH + DIN1_WIDTH;
    localparam int RW   = ACC_WIDTH + 1;
    localparam int LAST = NUM_STAGE - 1;

    localparam logic signed [RW-1:0] HALF = RW'(1) << (SHIFT - 1);
    localparam logic signed [RW-1:0] DMAX = (RW'(1) << (DOUT_WIDTH - 1)) - RW'(1);
    localparam logic signed [RW-1:0] DMIN = ~DMAX;

    // One extra bit keeps the rounding offset from wrapping the accumulator.
    function automatic logic signed [RW-1:0] round_shift(input logic signed [ACC_WIDTH-1:0] a);
        logic signed [RW-1:0] t;
        t = {a[ACC_WIDTH-1], a} + HALF;
        return t >>> SHIFT;
    endfunction

    function automatic logic [DOUT_WIDTH:0] saturate(input logic signed [RW-1:0] r);
        if (r > DMAX)
            return {1'b1, DMAX[DOUT_WIDTH-1:0]};
        else if (r < DMIN)
            return {1'b1, DMIN[DOUT_WIDTH-1:0]};
        else
            return {1'b0, r[DOUT_WIDTH-1:0]};
    endfunction

    logic                        en;
    logic signed [PW-1:0]        mult;
    logic signed [PW-1:0]        prod_p [NUM_STAGE];
    logic [NUM_STAGE-1:0]        vld_p;
    logic [NUM_STAGE-1:0]        first_p;
    logic [NUM_STAGE-1:0]        last_p;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [RW-1:0]        rounded;
    logic [DOUT_WIDTH:0]         clipped;
    logic                        step;
    logic                        load;

    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;
    assign mult     = din0 * din1;

    // Product pipeline: control bits carry reset, data registers do not.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld_p <= '0;
        end else if (en) begin
            vld_p[0] <= in_valid;
            for (int i = 1; i < NUM_STAGE; i++)
                vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge ap_clk) begin
        if (en) begin
            prod_p[0]  <= mult;
            first_p[0] <= in_first;
            last_p[0]  <= in_last;
            for (int i = 1; i < NUM_STAGE; i++) begin
                prod_p[i]  <= prod_p[i-1];
                first_p[i] <= first_p[i-1];
                last_p[i]  <= last_p[i-1];
            end
        end
    end

    // Accumulate / round / saturate at the pipeline tail
    always_comb begin
        prod_ext = ACC_WIDTH'(prod_p[LAST]);
        acc_next = first_p[LAST] ? prod_ext : acc + prod_ext;
        rounded  = round_shift(acc_next);
        clipped  = saturate(rounded);
        step     = en && vld_p[LAST];
        load     = step && last_p[LAST];
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc       <= '0;
            dout      <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (step)
                acc <= acc_next;
            if (load) begin
                dout      <= clipped[DOUT_WIDTH-1:0];
                out_sat   <= clipped[DOUT_WIDTH];
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multirate_v5_mac_pipe.sv
// Scoreboard bench for multirate_v5_mac_pipe: directed test-plan cases plus
// randomized frames checked against a plain-arithmetic reference model.
module tb_multirate_v5_mac_pipe;

    localparam int DIN0_W = 16;
    localparam int DIN1_W = 13;
    localparam int ACC_W  = 40;
    localparam int DOUT_W = 16;
    localparam int SH     = 12;
    localparam int NS     = 2;

    logic                     ap_clk = 1'b0;
    logic                     ap_rst_n;
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_first;
    logic                     in_last;
    logic signed [DIN0_W-1:0] din0;
    logic signed [DIN1_W-1:0] din1;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic signed [DOUT_W-1:0] dout;
    logic                     out_sat;

    int checks = 0;
    int errors = 0;
    logic [DOUT_W:0] exp_q[$];
    logic [DOUT_W:0] exp_item;
    longint model_acc = 0;
    logic ready_force = 1'b1;
    logic rand_ready  = 1'b0;

    multirate_v5_mac_pipe #(
        .DIN0_WIDTH(DIN0_W), .DIN1_WIDTH(DIN1_W), .ACC_WIDTH(ACC_W),
        .DOUT_WIDTH(DOUT_W), .SHIFT(SH), .NUM_STAGE(NS)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_first(in_first), .in_last(in_last),
        .din0(din0), .din1(din1),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .out_sat(out_sat)
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) begin
        #1;
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    // Expected result of a completed frame sum, from the arithmetic rules.
    function automatic logic [DOUT_W:0] model_result(input longint s);
        longint r;
        longint hi;
        longint lo;
        r  = (s + (64'sd1 <<< (SH - 1))) >>> SH;
        hi = (64'sd1 <<< (DOUT_W - 1)) - 1;
        lo = -(64'sd1 <<< (DOUT_W - 1));
        if (r > hi) return {1'b1, DOUT_W'(hi)};
        if (r < lo) return {1'b1, DOUT_W'(lo)};
        return {1'b0, DOUT_W'(r)};
    endfunction

    task automatic model_accept(input longint a, input longint b, input logic f, input logic l);
        longint p;
        p = a * b;
        model_acc = f ? p : model_acc + p;
        if (l) exp_q.push_back(model_result(model_acc));
    endtask

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every transfer on the output handshake pops one expectation.
    always @(negedge ap_clk) begin
        if (ap_rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got dout=%0d sat=%0b, expected no result", dout, out_sat);
            end else begin
                exp_item = exp_q.pop_front();
                if ({out_sat, dout} !== exp_item) begin
                    errors++;
                    $display("FAIL result: got dout=%0d sat=%0b, expected dout=%0d sat=%0b",
                             dout, out_sat, $signed(exp_item[DOUT_W-1:0]), exp_item[DOUT_W]);
                end
            end
        end
    end

    task automatic send_beat(input logic signed [DIN0_W-1:0] a, input logic signed [DIN1_W-1:0] b,
                             input logic f, input logic l);
        int   waited;
        logic took;
        waited = 0;
        took   = 1'b0;
        in_valid = 1'b1; din0 = a; din1 = b; in_first = f; in_last = l;
        while (!took) begin
            @(negedge ap_clk);
            took = in_ready;
            @(posedge ap_clk);
            #1;
            if (!took) begin
                waited++;
                if (waited > 200) begin
                    checks++; errors++;
                    $display("FAIL accept_timeout: got no acceptance, expected within 200 cycles");
                    break;
                end
            end
        end
        in_valid = 1'b0;
        if (took) model_accept(longint'(a), longint'(b), f, l);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge ap_clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(posedge ap_clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
        end
    endtask

    initial begin
        ap_rst_n = 1'b0;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; din0 = '0; din1 = '0;
        #2;
        check("reset_out_valid", out_valid, 0);
        check("reset_dout", dout, 0);
        check("reset_out_sat", out_sat, 0);
        check("reset_in_ready", in_ready, 1);
        idle(3);
        ap_rst_n = 1'b1;
        idle(2);

        // Single-beat frame and latency
        send_beat(16'sd1000, 13'sd2048, 1'b1, 1'b1);
        check("latency_accept_edge", out_valid, 0);
        for (int k = 1; k <= NS; k++) begin
            @(posedge ap_clk);
            #1;
            check("latency", out_valid, (k == NS) ? 1 : 0);
        end
        check("single_dout", dout, 500);
        check("single_sat", out_sat, 0);
        drain();

        // Rounding half toward +inf
        send_beat(-16'sd3, 13'sd2048, 1'b1, 1'b1);
        send_beat(16'sd3, 13'sd2048, 1'b1, 1'b1);
        drain();

        // Four-beat frame, back-to-back then with a bubble
        for (int i = 0; i < 4; i++)
            send_beat(16'(100 * (i + 1)), 13'sd2048, i == 0, i == 3);
        drain();
        for (int i = 0; i < 4; i++) begin
            if (i == 2) idle(2);
            send_beat(16'(100 * (i + 1)), 13'sd2048, i == 0, i == 3);
        end
        drain();

        // Saturation both ways
        for (int i = 0; i < 4; i++)
            send_beat(16'sd32767, 13'sd4095, i == 0, i == 3);
        for (int i = 0; i < 4; i++)
            send_beat(-16'sd32768, 13'sd4095, i == 0, i == 3);
        drain();

        // Backpressure: two results held behind out_ready=0
        ready_force = 1'b0;
        idle(1);
        send_beat(16'sd1000, 13'sd2048, 1'b1, 1'b1);
        send_beat(16'sd4, 13'sd2048, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(posedge ap_clk);
            #1;
            check("stall_in_ready", in_ready, 0);
            check("stall_dout", dout, 500);
            check("stall_out_valid", out_valid, 1);
        end
        ready_force = 1'b1;
        drain();

        // Asynchronous reset in the middle of a frame
        send_beat(16'sd100, 13'sd2048, 1'b1, 1'b0);
        send_beat(16'sd200, 13'sd2048, 1'b0, 1'b0);
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_dout", dout, 0);
        check("midreset_out_sat", out_sat, 0);
        check("midreset_in_ready", in_ready, 1);
        exp_q.delete();
        model_acc = 0;
        idle(2);
        ap_rst_n = 1'b1;
        idle(1);
        send_beat(16'sd8, 13'sd1024, 1'b1, 1'b1);
        drain();

        // Randomized frames with bubbles and random backpressure
        rand_ready = 1'b1;
        for (int fr = 0; fr < 60; fr++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                send_beat(DIN0_W'($urandom), DIN1_W'($urandom), i == 0, i == len - 1);
            end
        end
        rand_ready  = 1'b0;
        ready_force = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
